// File: rtl/reg_scoreboard.sv
// Destination-register scoreboard for the EXE..MEM slots: ID-stage stall and forwarding selects.
// Define SCOREBOARD_FWD_EN to enable the forwarding selects and the load-use stall rule.
module reg_scoreboard #(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned REG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             issue_valid,
  input  logic             issue_wb_en,
  input  logic             issue_mem_r,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             flush,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             forward_en,
  output logic             hazard,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [2:0]       occupancy,
  output logic             busy
);

  logic [NUM_SLOTS-1:0]            valid_q, valid_d;
  logic [NUM_SLOTS-1:0]            wb_en_q, wb_en_d;
  logic [NUM_SLOTS-1:0][REG_W-1:0] dest_q, dest_d;
`ifdef SCOREBOARD_FWD_EN
  logic [NUM_SLOTS-1:0]            mem_r_q, mem_r_d;
`endif

  always_comb begin
    valid_d = valid_q;
    wb_en_d = wb_en_q;
    dest_d  = dest_q;
`ifdef SCOREBOARD_FWD_EN
    mem_r_d = mem_r_q;
`endif
    if (advance) begin
      for (int i = 1; i < NUM_SLOTS; i++) begin
        valid_d[i] = valid_q[i-1];
        wb_en_d[i] = wb_en_q[i-1];
        dest_d[i]  = dest_q[i-1];
`ifdef SCOREBOARD_FWD_EN
        mem_r_d[i] = mem_r_q[i-1];
`endif
      end
      valid_d[0] = issue_valid & ~flush;
      wb_en_d[0] = issue_wb_en;
      dest_d[0]  = issue_dest;
`ifdef SCOREBOARD_FWD_EN
      mem_r_d[0] = issue_mem_r;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wb_en_q <= '0;
      dest_q  <= '0;
`ifdef SCOREBOARD_FWD_EN
      mem_r_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      wb_en_q <= wb_en_d;
      dest_q  <= dest_d;
`ifdef SCOREBOARD_FWD_EN
      mem_r_q <= mem_r_d;
`endif
    end
  end

  logic [NUM_SLOTS-1:0] match1, match2;
  logic                 any_match;

  always_comb begin
    match1    = '0;
    match2    = '0;
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match1[i] = valid_q[i] & wb_en_q[i] & (dest_q[i] == src1);
      match2[i] = valid_q[i] & wb_en_q[i] & (dest_q[i] == src2) & two_src;
      occupancy = occupancy + 3'(valid_q[i] & wb_en_q[i]);
    end
    any_match = (|match1) | (|match2);
    busy      = (occupancy != 3'd0);
  end

`ifdef SCOREBOARD_FWD_EN
  always_comb begin
    fwd_sel1 = 2'd0;
    fwd_sel2 = 2'd0;
    if (forward_en) begin
      // Only a load still in EXE cannot be forwarded in time.
      hazard = (match1[0] | match2[0]) & mem_r_q[0];
    end else begin
      hazard = any_match;
    end
    if (forward_en && !hazard) begin
      if (match1[0])                fwd_sel1 = 2'd1;
      else if (match1[NUM_SLOTS-1]) fwd_sel1 = 2'd2;
      if (match2[0])                fwd_sel2 = 2'd1;
      else if (match2[NUM_SLOTS-1]) fwd_sel2 = 2'd2;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{forward_en, issue_mem_r};
  assign hazard     = any_match;
  assign fwd_sel1   = 2'd0;
  assign fwd_sel2   = 2'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow the build (SCOREBOARD_FWD_EN or not).
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FwdBuild = 1'b1;
`else
  localparam bit FwdBuild = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, advance, issue_valid, issue_wb_en, issue_mem_r, flush, two_src, forward_en;
  logic [3:0] issue_dest, src1, src2;
  logic       hazard, busy;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [2:0] occupancy;

  int nvec = 0;
  int nerr = 0;

  reg_scoreboard #(.NUM_SLOTS(2), .REG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .issue_valid(issue_valid),
    .issue_wb_en(issue_wb_en),
    .issue_mem_r(issue_mem_r),
    .issue_dest (issue_dest),
    .flush      (flush),
    .src1       (src1),
    .src2       (src2),
    .two_src    (two_src),
    .forward_en (forward_en),
    .hazard     (hazard),
    .fwd_sel1   (fwd_sel1),
    .fwd_sel2   (fwd_sel2),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [3:0] d, input logic wb, input logic ld);
    issue_valid = 1'b1; issue_wb_en = wb; issue_mem_r = ld; issue_dest = d; advance = 1'b1;
    tick();
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_mem_r = 1'b0; issue_dest = 4'd0;
  endtask

  task automatic drain();
    issue_valid = 1'b0; flush = 1'b0; advance = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src1 = 4'($urandom_range(0, 15));
      src2 = 4'($urandom_range(0, 15));
      two_src = 1'b1;
      forward_en = 1'($urandom_range(0, 1));
      settle();
      nvec++;
      if (hazard !== 1'b0 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || occupancy !== 3'd0
          || busy !== 1'b0) begin
        nerr++;
        $display("FAIL reset_idle[%0d]: hz=%b s1=%0d s2=%0d occ=%0d busy=%b want 0/0/0/0/0",
                 i, hazard, fwd_sel1, fwd_sel2, occupancy, busy);
      end
      tick();
    end
  endtask

  task automatic test_no_fwd_aging();
    forward_en = 1'b0; two_src = 1'b0; src1 = 4'd3; src2 = 4'd0;
    issue(4'd3, 1'b1, 1'b0);
    settle();
    nvec++;
    if (hazard !== 1'b1 || occupancy !== 3'd1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL age_slot0: hz=%b occ=%0d busy=%b want 1/1/1", hazard, occupancy, busy);
    end
    advance = 1'b1;
    tick();
    nvec++;
    if (hazard !== 1'b1 || occupancy !== 3'd1 || fwd_sel1 !== 2'd0) begin
      nerr++;
      $display("FAIL age_slot1: hz=%b occ=%0d s1=%0d want 1/1/0", hazard, occupancy, fwd_sel1);
    end
    tick();
    nvec++;
    if (hazard !== 1'b0 || occupancy !== 3'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL age_retired: hz=%b occ=%0d busy=%b want 0/0/0", hazard, occupancy, busy);
    end
  endtask

  task automatic test_youngest_wins();
    issue(4'd5, 1'b1, 1'b0);
    issue(4'd5, 1'b1, 1'b0);
    advance = 1'b0;
    forward_en = 1'b1; two_src = 1'b1; src1 = 4'd0; src2 = 4'd5;
    settle();
    nvec++;
    if (hazard !== !FwdBuild || fwd_sel2 !== (FwdBuild ? 2'd1 : 2'd0) || fwd_sel1 !== 2'd0
        || occupancy !== 3'd2) begin
      nerr++;
      $display("FAIL youngest: hz=%b s1=%0d s2=%0d occ=%0d want %b/0/%0d/2", hazard, fwd_sel1,
               fwd_sel2, occupancy, !FwdBuild, FwdBuild ? 1 : 0);
    end
    forward_en = 1'b0;
    settle();
    nvec++;
    if (hazard !== 1'b1 || fwd_sel2 !== 2'd0) begin
      nerr++;
      $display("FAIL youngest_nofwd: hz=%b s2=%0d want 1/0", hazard, fwd_sel2);
    end
    two_src = 1'b0;
    settle();
    nvec++;
    if (hazard !== 1'b0 || fwd_sel2 !== 2'd0) begin
      nerr++;
      $display("FAIL src2_dead: hz=%b s2=%0d want 0/0", hazard, fwd_sel2);
    end
    drain();
  endtask

  task automatic test_load_use();
    forward_en = 1'b1; two_src = 1'b0; src1 = 4'd2; src2 = 4'd0;
    issue(4'd2, 1'b1, 1'b1);
    settle();
    nvec++;
    if (hazard !== 1'b1 || fwd_sel1 !== 2'd0) begin
      nerr++;
      $display("FAIL load_use: hz=%b s1=%0d want 1/0", hazard, fwd_sel1);
    end
    advance = 1'b1;
    tick();
    nvec++;
    if (hazard !== !FwdBuild || fwd_sel1 !== (FwdBuild ? 2'd2 : 2'd0)) begin
      nerr++;
      $display("FAIL load_mem_fwd: hz=%b s1=%0d want %b/%0d", hazard, fwd_sel1, !FwdBuild,
               FwdBuild ? 2 : 0);
    end
    drain();
  endtask

  task automatic test_flush_freeze();
    forward_en = 1'b0; two_src = 1'b0; src1 = 4'd7;
    flush = 1'b1;
    issue(4'd7, 1'b1, 1'b0);
    flush = 1'b0;
    settle();
    nvec++;
    if (hazard !== 1'b0 || occupancy !== 3'd0) begin
      nerr++;
      $display("FAIL flush_bubble: hz=%b occ=%0d want 0/0", hazard, occupancy);
    end
    issue(4'd7, 1'b1, 1'b0);
    advance = 1'b0; issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd9; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      src1 = 4'd7;
      settle();
      nvec++;
      if (hazard !== 1'b1 || occupancy !== 3'd1) begin
        nerr++;
        $display("FAIL frozen_hold[%0d]: hz=%b occ=%0d want 1/1", i, hazard, occupancy);
      end
      src1 = 4'd9;
      settle();
      nvec++;
      if (hazard !== 1'b0) begin
        nerr++;
        $display("FAIL frozen_ignore[%0d]: hz=%b want 0", i, hazard);
      end
    end
    issue_valid = 1'b0; issue_wb_en = 1'b0; flush = 1'b0;
    drain();
    // A non-writing instruction is tracked but never matches nor counts.
    src1 = 4'd6;
    issue(4'd6, 1'b0, 1'b0);
    settle();
    nvec++;
    if (hazard !== 1'b0 || occupancy !== 3'd0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL no_wb: hz=%b occ=%0d busy=%b want 0/0/0", hazard, occupancy, busy);
    end
    drain();
  endtask

  task automatic test_back_to_back_reset();
    forward_en = 1'b0; two_src = 1'b1; src1 = 4'd1; src2 = 4'd4;
    issue(4'd1, 1'b1, 1'b0);
    issue(4'd4, 1'b1, 1'b0);
    settle();
    nvec++;
    if (occupancy !== 3'd2 || hazard !== 1'b1) begin
      nerr++;
      $display("FAIL full: occ=%0d hz=%b want 2/1", occupancy, hazard);
    end
    rst = 1'b1; issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = 4'd1; advance = 1'b1;
    tick();
    rst = 1'b0; issue_valid = 1'b0; issue_wb_en = 1'b0; advance = 1'b0;
    settle();
    nvec++;
    if (occupancy !== 3'd0 || busy !== 1'b0 || hazard !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset: occ=%0d busy=%b hz=%b want 0/0/0", occupancy, busy, hazard);
    end
  endtask

  initial begin
    rst = 1'b1; advance = 1'b0; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_mem_r = 1'b0;
    issue_dest = 4'd0; flush = 1'b0; src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
    forward_en = 1'b0;
    tick();
    test_reset();
    test_no_fwd_aging();
    test_youngest_wins();
    test_load_use();
    test_flush_freeze();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks the destination registers of instructions in flight between ID and write-back, and answers ID-stage source lookups with a stall request and forwarding selects. It is the producer side of the EXE/MEM destination information that the ID-stage hazard check consumes. Pipeline control records each instruction as it leaves ID, and the block shifts the records in lock-step with the pipeline. It sits beside the ID/EXE and EXE/MEM pipeline registers.

## Interface
- NUM_SLOTS, 2, tracked stages after ID (slot 0 = EXE, slot 1 = MEM); legal values 1..4
- REG_W, 4, register index width (16 architectural registers)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- advance  in  1  pipeline moves one stage this cycle; 0 = frozen (memory wait)
- issue_valid  in  1  an instruction leaves ID into EXE this cycle
- issue_wb_en  in  1  issuing instruction writes a register
- issue_mem_r  in  1  issuing instruction is a load
- issue_dest  in  REG_W  destination of the issuing instruction
- flush  in  1  branch taken: the issuing instruction is killed
- src1, src2  in  REG_W  ID-stage source registers
- two_src  in  1  src2 is a live operand
- forward_en  in  1  forwarding paths enabled
- hazard  out  1  ID must stall this cycle
- fwd_sel1, fwd_sel2  out  2  operand source: 0 = register file, 1 = slot 0 producer, 2 = slot NUM_SLOTS-1 producer
- occupancy  out  3  count of valid slots with wb_en=1
- busy  out  1  occupancy != 0

## Operation
- Each slot stores {valid, wb_en, mem_r, dest}. The shift register is slot 0 → slot NUM_SLOTS-1, and the oldest record drops off at write-back.
- On a cycle with advance=1:
  - slot[i] <= slot[i-1] for i ≥ 1.
  - slot 0 <= {issue_valid & ~flush, issue_wb_en, issue_mem_r, issue_dest}.
- On a cycle with advance=0: all slots hold; issue_valid and flush are ignored.
- A slot is a match for a source s when valid & wb_en & (dest == s). src2 is examined only when two_src=1.
- Hazard without forwarding (forward_en=0): hazard = any match on either live source in any slot.
- Hazard with forwarding (forward_en=1): hazard = a live source matches slot 0 and slot 0 has mem_r=1 (load-use).
- Forwarding select: the youngest matching slot wins. A match in slot 0 gives sel 1; otherwise a match in the oldest slot gives sel 2. Middle slots (NUM_SLOTS > 2) count toward hazard only.
- fwd_selN = 0 whenever forward_en=0, hazard=1, or operand N has no match. fwd_sel2 = 0 when two_src=0.
- All outputs are combinational from the slot state and the current inputs. There is no input-to-state combinational loop.
- Upstream gates issue_valid with ~hazard. If issue_valid=1 while hazard=1, the record is still stored as presented.

## Timing
- Reset: all slots invalid. hazard=0, fwd_sel1=fwd_sel2=0, occupancy=0, busy=0 in the cycle after rst is sampled high.
- rst overrides advance, issue_valid and flush. Asserting rst mid-operation empties the scoreboard in one edge.
- A record issued at edge N is visible in slot 0 for lookups in cycle N+1, and in slot k at N+1+k if advance stays high.
- A record leaves the tracker NUM_SLOTS advancing edges after issue.
- flush=1 with advance=1: slot 0 receives a bubble, and older slots shift normally.
- Frozen pipeline: records do not age, so hazard persists across frozen cycles.
- occupancy saturates at NUM_SLOTS, which is at most 4 with a 3-bit width.

## Configuration
- Macro: SCOREBOARD_FWD_EN.
- When defined: forward_en is honoured, the load-use rule applies, and fwd_sel1/fwd_sel2 are generated.
- When undefined: forward_en is ignored, hazard is the any-match rule, fwd_sel1/fwd_sel2 are tied to 0, and the mem_r storage is removed.

## Test plan
- Reset then idle: hazard=0, fwd_sel=0/0, occupancy=0 for 10 cycles with random src1/src2.
- Issue dest=R3 wb_en=1, then lookup src1=R3 with forward_en=0 → hazard=1 in slot 0 and again after one advance (slot 1). After the second advance → hazard=0, occupancy=0.
- forward_en=1, issue ALU dest=R5 then dest=R5 again, lookup src2=R5, two_src=1 → hazard=0, fwd_sel2=1 (youngest wins).
- forward_en=1, load dest=R2 in slot 0, src1=R2 → hazard=1. After one advance with bubble issue → hazard=0, fwd_sel1=2.
- Issue dest=R7 with flush=1, advance=1 → occupancy stays 0 and src1=R7 gives hazard=0. Repeat with advance=0 for 3 cycles: the held record keeps hazard=1.
- Fill both slots, assert rst for one cycle mid-stream → next cycle occupancy=0, busy=0, hazard=0.
